// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package me_pkg;

    localparam int BLK_DIM       = 8;   // block edge in pixels
    localparam int WORDS_PER_BLK = 16;  // 8 rows x 2 words of 4 pixels
    localparam int WORD_BYTES    = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2
    } cur_fetch_state_t;

endpackage

// File: rtl/cur_fetch_fifo2.sv
// 2-entry 32-bit FIFO used to hide the frame-memory read latency.
// Latency: a pushed word is visible on head the cycle after the push.
// Backpressure: none internally; the caller must not push when full without popping.
// Ports: clk, rst (async active-high), push/din write side, pop read side,
//        head = oldest entry, count = number of stored entries (0..2).
module cur_fetch_fifo2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] head,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // When full, a simultaneous pop frees the head slot, which is the one wr_ptr points at.
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= 32'd0;
            mem[1] <= 32'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cur_fetch.sv
// Current-block fetch engine: walks the frame in 8x8 blocks (raster order) and streams
// each block as 16 little-endian words to the consumer. Latency: read strobe to cur_valid
// is 2 cycles; 1 word/cycle sustained. Backpressure: need_cur gates pops; reads are
// throttled so FIFO entries plus in-flight reads never exceed 2.
// Ports: clk, rst (async active-high), next_block (advance pulse), need_cur/cur_in/cur_valid
//        (consumer side), mem_rd_en/mem_addr/mem_rd_data (frame memory, 1-cycle read),
//        blk_x/blk_y (block being fetched), frame_done (last block consumed).
// Optional feature macro: CUR_FETCH_FRAME_WRAP_EN -- restart at block (0,0) after the
// last block instead of parking in DONE.
module cur_fetch
    import me_pkg::*;
#(
    parameter int FRAME_W   = 32,
    parameter int FRAME_H   = 16,
    parameter int ADDR_W    = 11,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next_block,
    input  logic              need_cur,
    output logic [31:0]       cur_in,
    output logic              cur_valid,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [7:0]        blk_x,
    output logic [7:0]        blk_y,
    output logic              frame_done
);

`ifdef CUR_FETCH_FRAME_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [7:0] LAST_X = 8'(FRAME_W / BLK_DIM - 1);
    localparam logic [7:0] LAST_Y = 8'(FRAME_H / BLK_DIM - 1);
    localparam logic [4:0] N_WORDS = 5'(WORDS_PER_BLK);

    cur_fetch_state_t state;
    logic [4:0]       issued;     // reads issued for this block; low 4 bits are k
    logic [4:0]       popped;     // words handed to the consumer for this block
    logic             inflight;   // a read was issued last cycle, data arrives now
    logic             pend;       // early next_block seen during FETCH
    logic [1:0]       fifo_count;
    logic [31:0]      fifo_head;
    logic             pop;
    logic             last_word_pop;
    logic             last_blk;
    logic [7:0]       next_x;
    logic [7:0]       next_y;
    int               row;

    cur_fetch_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (mem_rd_data),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign cur_valid = (fifo_count != 2'd0);
    assign cur_in    = fifo_head;
    assign pop       = need_cur & cur_valid;

    // Occupancy after this cycle's pop must leave room for the word being requested now.
    // Gated by rst so the strobe is low while reset is held.
    assign mem_rd_en = !rst && (state == FETCH) && (issued < N_WORDS) &&
                       (({1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);

    assign row      = int'(blk_y) * BLK_DIM + int'(issued[3:1]);
    assign mem_addr = ADDR_W'(BASE_ADDR + row * FRAME_W + int'(blk_x) * BLK_DIM +
                              (issued[0] ? WORD_BYTES : 0));

    assign last_word_pop = (state == FETCH) && pop && (popped == N_WORDS - 5'd1);
    assign last_blk      = (blk_x == LAST_X) && (blk_y == LAST_Y);
    assign frame_done    = last_word_pop && last_blk;

    // Raster advance; past the last block this wraps to (0,0), used only when WRAP_EN.
    assign next_x = (blk_x == LAST_X) ? 8'd0 : blk_x + 8'd1;
    assign next_y = (blk_x != LAST_X) ? blk_y :
                    (blk_y == LAST_Y) ? 8'd0 : blk_y + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            blk_x    <= 8'd0;
            blk_y    <= 8'd0;
            issued   <= 5'd0;
            popped   <= 5'd0;
            inflight <= 1'b0;
            pend     <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en) begin
                issued <= issued + 5'd1;
            end
            if (pop) begin
                popped <= popped + 5'd1;
            end
            case (state)
                FETCH: begin
                    if (last_word_pop) begin
                        pend <= 1'b0;
                        if (last_blk && !WRAP_EN) begin
                            state <= DONE;
                        end else if (pend || next_block) begin
                            // WAIT is entered and left in the same cycle.
                            blk_x  <= next_x;
                            blk_y  <= next_y;
                            issued <= 5'd0;
                            popped <= 5'd0;
                            state  <= FETCH;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (next_block) begin
                        pend <= 1'b1;
                    end
                end
                WAIT: begin
                    if (next_block) begin
                        blk_x  <= next_x;
                        blk_y  <= next_y;
                        issued <= 5'd0;
                        popped <= 5'd0;
                        state  <= FETCH;
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cur_fetch.sv
module tb_cur_fetch;

    localparam int FW = 32;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          next_block = 1'b0;
    logic          need_cur = 1'b0;
    logic [31:0]   cur_in;
    logic          cur_valid;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data = 32'd0;
    logic [7:0]    blk_x;
    logic [7:0]    blk_y;
    logic          frame_done;

    cur_fetch #(.FRAME_W(32), .FRAME_H(16), .ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .next_block  (next_block),
        .need_cur    (need_cur),
        .cur_in      (cur_in),
        .cur_valid   (cur_valid),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .blk_x       (blk_x),
        .blk_y       (blk_y),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Byte-addressed frame memory with 1-cycle read latency.
    logic [7:0] mem [0:2047];
    bit req = 1'b0;
    int req_a = 0;

    // Observation log, sampled mid-cycle.
    int          cyc = 0;
    int          rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [31:0] pop_q[$];
    int          pop_cyc_q[$];
    int          fd_cnt = 0;
    int          fd_cyc = -1;
    int          vld_first = -1;
    int          max_out = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        req = mem_rd_en;
        req_a = int'(mem_addr);
        if (!rst) begin
            if (mem_rd_en) begin
                rd_addr_q.push_back(int'(mem_addr));
                rd_cyc_q.push_back(cyc);
            end
            if (need_cur && cur_valid) begin
                pop_q.push_back(cur_in);
                pop_cyc_q.push_back(cyc);
            end
            if (frame_done) begin
                fd_cnt = fd_cnt + 1;
                fd_cyc = cyc;
            end
            if (cur_valid && vld_first < 0) vld_first = cyc;
            if (rd_addr_q.size() - pop_q.size() > max_out) max_out = rd_addr_q.size() - pop_q.size();
        end
    end

    always @(posedge clk) begin
        if (req) mem_rd_data <= {mem[req_a+3], mem[req_a+2], mem[req_a+1], mem[req_a]};
        else     mem_rd_data <= $urandom;
    end

    // Reference: block (bx,by) word k is row k/2, half k%2 of the 8x8 block.
    function automatic int exp_addr(int bx, int by, int k);
        return (by * 8 + k / 2) * FW + bx * 8 + (k % 2) * 4;
    endfunction

    function automatic logic [31:0] exp_word(int bx, int by, int k);
        int a;
        a = exp_addr(bx, by, k);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        pop_q.delete();
        pop_cyc_q.delete();
        fd_cnt = 0;
        fd_cyc = -1;
        vld_first = -1;
        max_out = 0;
    endtask

    task automatic pulse_next();
        next_block = 1'b1;
        tick();
        next_block = 1'b0;
    endtask

    // mode 0: need_cur held, 1: toggled each cycle, 2: random.
    task automatic drive_until_pops(input int n, input int mode, output bit ok);
        int budget;
        int ph;
        budget = 300;
        ph = 0;
        ok = 1'b0;
        while (budget > 0) begin
            if (pop_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            case (mode)
                0:       need_cur = 1'b1;
                1:       need_cur = ph[0];
                default: need_cur = 1'($urandom_range(0, 1));
            endcase
            ph++;
            tick();
            budget--;
        end
        need_cur = 1'b0;
    endtask

    task automatic check_block_data(input string name, input int base, input int bx, input int by);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (base + k >= pop_q.size() || pop_q[base+k] !== exp_word(bx, by, k)) begin
                failures++;
                $display("FAIL %s word %0d: got %h expected %h", name, k,
                         (base + k < pop_q.size()) ? pop_q[base+k] : 32'hx, exp_word(bx, by, k));
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        need_cur = 1'b0;
        next_block = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_int("reset cur_in", int'(cur_in), 0);
        check_int("reset cur_valid", int'(cur_valid), 0);
        check_int("reset mem_rd_en", int'(mem_rd_en), 0);
        check_int("reset mem_addr", int'(mem_addr), 0);
        check_int("reset blk_x", int'(blk_x), 0);
        check_int("reset blk_y", int'(blk_y), 0);
        check_int("reset frame_done", int'(frame_done), 0);
        tick();
    endtask

    task automatic test_first_block();
        bit ok;
        int c0;
        clear_mon();
        need_cur = 1'b1;
        rst = 1'b0;
        c0 = cyc + 1;
        drive_until_pops(16, 0, ok);
        check_int("first block completes", int'(ok), 1);
        need_cur = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check_int("first block cur_valid idle", int'(cur_valid), 0);
        tick();
        need_cur = 1'b0;
        check_int("first block read count", rd_addr_q.size(), 16);
        for (int k = 0; k < 16 && k < rd_addr_q.size(); k++)
            check_int("first block addr", rd_addr_q[k], exp_addr(0, 0, k));
        if (rd_cyc_q.size() > 0) begin
            check_int("first read cycle", rd_cyc_q[0], c0);
            check_int("read to valid latency", vld_first - rd_cyc_q[0], 2);
        end
        check_int("pop count", pop_q.size(), 16);
        if (pop_cyc_q.size() == 16)
            check_int("pops consecutive", pop_cyc_q[15] - pop_cyc_q[0], 15);
        check_block_data("first block", 0, 0, 0);
    endtask

    task automatic test_wait_advance();
        bit ok;
        for (int b = 1; b <= 4; b++) begin
            clear_mon();
            pulse_next();
            check_int("advance blk_x", int'(blk_x), b % 4);
            check_int("advance blk_y", int'(blk_y), b / 4);
            drive_until_pops(16, 0, ok);
            check_int("advance block completes", int'(ok), 1);
            if (rd_addr_q.size() > 0)
                check_int("advance first addr", rd_addr_q[0], exp_addr(b % 4, b / 4, 0));
            check_block_data("advance block", 0, b % 4, b / 4);
        end
    endtask

    task automatic test_early_next();
        bit ok;
        rst = 1'b1;
        tick();
        clear_mon();
        rst = 1'b0;
        need_cur = 1'b1;
        repeat (3) tick();
        pulse_next();
        repeat (2) tick();
        pulse_next();
        drive_until_pops(32, 0, ok);
        check_int("early next completes", int'(ok), 1);
        need_cur = 1'b1;
        repeat (6) tick();
        need_cur = 1'b0;
        check_int("early next collapsed reads", rd_addr_q.size(), 32);
        if (rd_addr_q.size() > 16 && pop_cyc_q.size() > 15) begin
            check_int("early next no idle cycle", rd_cyc_q[16], pop_cyc_q[15] + 1);
            check_int("early next addr", rd_addr_q[16], 8);
        end
        check_int("early next blk_x", int'(blk_x), 1);
        check_int("early next blk_y", int'(blk_y), 0);
        check_block_data("early next block", 16, 1, 0);
    endtask

    task automatic test_backpressure();
        bit ok;
        for (int m = 1; m <= 2; m++) begin
            clear_mon();
            pulse_next();
            drive_until_pops(16, m, ok);
            check_int("backpressure completes", int'(ok), 1);
            need_cur = 1'b1;
            repeat (4) tick();
            need_cur = 1'b0;
            check_int("backpressure pop count", pop_q.size(), 16);
            check_int("backpressure read count", rd_addr_q.size(), 16);
            checks++;
            if (max_out > 2) begin
                failures++;
                $display("FAIL backpressure outstanding: got %0d expected at most 2", max_out);
            end
            check_block_data("backpressure block", 0, m + 1, 0);
        end
    endtask

    task automatic test_last_block();
        bit ok;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            pulse_next();
            drive_until_pops(16 * (i + 1), 2, ok);
            check_int("row1 block completes", int'(ok), 1);
        end
        for (int i = 0; i < 4; i++) check_block_data("row1 block", 16 * i, i, 1);
        check_int("frame_done pulses", fd_cnt, 1);
        if (pop_cyc_q.size() == 64) check_int("frame_done cycle", fd_cyc, pop_cyc_q[63]);
`ifdef CUR_FETCH_FRAME_WRAP_EN
        clear_mon();
        pulse_next();
        check_int("wrap blk_x", int'(blk_x), 0);
        check_int("wrap blk_y", int'(blk_y), 0);
        drive_until_pops(16, 0, ok);
        check_int("wrap block completes", int'(ok), 1);
        if (rd_addr_q.size() > 0) check_int("wrap first addr", rd_addr_q[0], 0);
        check_block_data("wrap block", 0, 0, 0);
`else
        clear_mon();
        pulse_next();
        need_cur = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        check_int("done cur_valid", int'(cur_valid), 0);
        tick();
        need_cur = 1'b0;
        check_int("done reads", rd_addr_q.size(), 0);
        check_int("done pops", pop_q.size(), 0);
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        int budget;
        rst = 1'b1;
        tick();
        clear_mon();
        rst = 1'b0;
        need_cur = 1'b1;
        budget = 50;
        while (pop_q.size() < 7 && budget > 0) begin
            tick();
            budget--;
        end
        check_int("mid reset reached word 7", int'(pop_q.size() >= 7), 1);
        rst = 1'b1;
        @(negedge clk);
        check_int("mid reset cur_valid", int'(cur_valid), 0);
        check_int("mid reset mem_rd_en", int'(mem_rd_en), 0);
        check_int("mid reset mem_addr", int'(mem_addr), 0);
        check_int("mid reset cur_in", int'(cur_in), 0);
        check_int("mid reset frame_done", int'(frame_done), 0);
        tick();
        tick();
        clear_mon();
        rst = 1'b0;
        drive_until_pops(16, 0, ok);
        check_int("restart completes", int'(ok), 1);
        need_cur = 1'b1;
        repeat (4) tick();
        need_cur = 1'b0;
        check_int("restart pop count", pop_q.size(), 16);
        if (rd_addr_q.size() > 0) check_int("restart first addr", rd_addr_q[0], 0);
        check_block_data("restart block", 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        test_reset();
        test_first_block();
        test_wait_advance();
        test_early_next();
        test_backpressure();
        test_last_block();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
